// File: rtl/i2s_audio_tx.sv
// ---------------------------------------------------------------------------
// i2s_audio_tx
//   Stereo PCM to I2S serializer running from the 24.576 MHz audio clock.
//   One sample pair is accepted per frame through a one-entry holding
//   register; the frame is shifted out as two 32-bit slots (left, right)
//   with data and word select changing on BCLK falling edges.
//
// Parameters
//   DW       sample width (1..31), two's complement, MSB first
//   CLK_DIV  clk cycles per BCLK half-period (>= 1)
//
// Ports
//   clk           in   audio clock
//   rst_n         in   synchronous active-low reset
//   en            in   run enable
//   sample_l      in   left sample  [DW-1:0]
//   sample_r      in   right sample [DW-1:0]
//   sample_valid  in   sample pair offered
//   sample_ready  out  holding register empty
//   bclk          out  I2S bit clock
//   lrck          out  word select (0 = left, 1 = right)
//   sdata         out  serial data
//   frame_start   out  one-clk pulse when a frame is loaded
//   underflow     out  one-clk pulse when a frame is loaded with no sample
//
// Build option
//   I2S_LEFT_JUSTIFIED_EN  when defined, left-justified format (no one-bit
//                          delay after the word-select change).
// ---------------------------------------------------------------------------
module i2s_audio_tx #(
  parameter int DW      = 16,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] sample_l,
  input  logic [DW-1:0] sample_r,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          bclk,
  output logic          lrck,
  output logic          sdata,
  output logic          frame_start,
  output logic          underflow
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [5:0] L_LAST = 6'(DW);
  localparam logic [5:0] R_LAST = 6'(32 + DW);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Registered state
  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [5:0]       r_bit_cnt;
  logic             r_bclk;
  logic             r_lrck;
  logic             r_sdata;
  logic             r_frame_start;
  logic             r_underflow;
  logic             r_hold_full;
  logic [DW-1:0]    r_hold_l;
  logic [DW-1:0]    r_hold_r;
  logic [DW-1:0]    r_data_l;
  logic [DW-1:0]    r_data_r;

  // Next-state values
  logic [1:0]       w_state_n;
  logic [DIV_W-1:0] w_div_n;
  logic [5:0]       w_bit_n;
  logic             w_bclk_n;
  logic             w_lrck_n;
  logic             w_sdata_n;
  logic             w_div_wrap;
  logic             w_fall;
  logic             w_wrap;
  logic             w_accept;
  logic             w_load;
  logic             w_advance;
  logic [DW-1:0]    w_src_l;
  logic [DW-1:0]    w_src_r;

  // Serial bit for slot position b. Shifting the wanted bit up to the MSB
  // keeps the select index constant-width for any DW.
  function automatic logic f_slot_bit(input logic [5:0] b,
                                      input logic [DW-1:0] l,
                                      input logic [DW-1:0] r);
    logic [DW-1:0] sh;
    logic          bit_v;
    sh    = {DW{1'b0}};
    bit_v = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
    if (b < L_LAST) begin
      sh    = l << b;
      bit_v = sh[DW-1];
    end else if ((b >= 6'd32) && (b < R_LAST)) begin
      sh    = r << (b - 6'd32);
      bit_v = sh[DW-1];
    end else begin
      bit_v = 1'b0;
    end
`else
    // Standard I2S: MSB follows the word-select change by one bit.
    if ((b >= 6'd1) && (b <= L_LAST)) begin
      sh    = l << (b - 6'd1);
      bit_v = sh[DW-1];
    end else if ((b >= 6'd33) && (b <= R_LAST)) begin
      sh    = r << (b - 6'd33);
      bit_v = sh[DW-1];
    end else begin
      bit_v = 1'b0;
    end
`endif
    return bit_v;
  endfunction

  // FSM transitions, frame-load decision and bit-clock/counter next values.
  always_comb begin
    w_state_n  = r_state;
    w_div_n    = r_div_cnt;
    w_bit_n    = r_bit_cnt;
    w_bclk_n   = r_bclk;
    w_lrck_n   = r_lrck;
    w_sdata_n  = r_sdata;
    w_load     = 1'b0;
    w_advance  = 1'b0;
    w_div_wrap = (r_div_cnt == DIV_MAX);
    w_fall     = w_div_wrap & r_bclk;
    w_wrap     = w_fall & (r_bit_cnt == 6'd63);
    w_accept   = sample_valid & ~r_hold_full;

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_n = ST_RUN;
          w_load    = 1'b1;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_advance = 1'b1;
        w_load    = w_wrap;
        if (en) begin
          w_state_n = ST_RUN;
        end else begin
          w_state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (en) begin
          // Re-enabled before the frame ended: behave exactly like RUN.
          w_advance = 1'b1;
          w_load    = w_wrap;
          w_state_n = ST_RUN;
        end else if (w_wrap) begin
          w_state_n = ST_IDLE;
        end else begin
          w_advance = 1'b1;
          w_state_n = ST_DRAIN;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // Data that the serial bit is taken from after this edge.
    if (w_load) begin
      w_src_l = r_hold_full ? r_hold_l : {DW{1'b0}};
      w_src_r = r_hold_full ? r_hold_r : {DW{1'b0}};
    end else begin
      w_src_l = r_data_l;
      w_src_r = r_data_r;
    end

    if (w_advance) begin
      if (w_div_wrap) begin
        w_div_n  = {DIV_W{1'b0}};
        w_bclk_n = ~r_bclk;
      end else begin
        w_div_n  = r_div_cnt + DIV_ONE;
        w_bclk_n = r_bclk;
      end
      if (w_fall) begin
        w_bit_n   = r_bit_cnt + 6'd1;
        w_lrck_n  = w_bit_n[5];
        w_sdata_n = f_slot_bit(w_bit_n, w_src_l, w_src_r);
      end else begin
        w_bit_n   = r_bit_cnt;
        w_lrck_n  = r_lrck;
        w_sdata_n = r_sdata;
      end
    end else begin
      // Idle, entry load or drain exit: counters and outputs restart at 0.
      w_div_n   = {DIV_W{1'b0}};
      w_bclk_n  = 1'b0;
      w_bit_n   = 6'd0;
      w_lrck_n  = 1'b0;
      w_sdata_n = w_load ? f_slot_bit(6'd0, w_src_l, w_src_r) : 1'b0;
    end
  end

  // FSM, counters and serial outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_div_cnt     <= {DIV_W{1'b0}};
      r_bit_cnt     <= 6'd0;
      r_bclk        <= 1'b0;
      r_lrck        <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_div_cnt     <= w_div_n;
      r_bit_cnt     <= w_bit_n;
      r_bclk        <= w_bclk_n;
      r_lrck        <= w_lrck_n;
      r_sdata       <= w_sdata_n;
      r_frame_start <= w_load;
      r_underflow   <= w_load & ~r_hold_full;
    end
  end

  // Holding register: an accept wins over a load, so a pair accepted while
  // an (underflowing) load happens is kept for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= {DW{1'b0}};
      r_hold_r    <= {DW{1'b0}};
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_l    <= sample_l;
      r_hold_r    <= sample_r;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Frame data register, captured at every frame load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_l <= {DW{1'b0}};
      r_data_r <= {DW{1'b0}};
    end else if (w_load) begin
      r_data_l <= w_src_l;
      r_data_r <= w_src_r;
    end
  end

  assign sample_ready = ~r_hold_full;
  assign bclk         = r_bclk;
  assign lrck         = r_lrck;
  assign sdata        = r_sdata;
  assign frame_start  = r_frame_start;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_audio_tx
//   Self-checking bench for i2s_audio_tx. A behavioural model tracks the
//   time since the last frame entry and derives BCLK, slot index, word select
//   and data bit arithmetically; a one-entry model of the holding register
//   predicts sample_ready, frame_start and underflow. Directed scenarios are
//   followed by a long randomized run.
// ---------------------------------------------------------------------------
module tb_i2s_audio_tx;

  localparam int DW       = 16;
  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 2 * CLK_DIV;
  localparam int FRAME    = 128 * CLK_DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] sample_l;
  logic [DW-1:0] sample_r;
  logic          sample_valid;
  logic          sample_ready;
  logic          bclk;
  logic          lrck;
  logic          sdata;
  logic          frame_start;
  logic          underflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic          m_running  = 1'b0;
  logic          m_draining = 1'b0;
  int            m_t        = 0;
  logic          m_full     = 1'b0;
  logic          m_fs       = 1'b0;
  logic          m_uf       = 1'b0;
  logic [DW-1:0] m_hl       = '0;
  logic [DW-1:0] m_hr       = '0;
  logic [DW-1:0] m_fl       = '0;
  logic [DW-1:0] m_fr       = '0;

  always #5 clk = ~clk;

  i2s_audio_tx #(.DW(DW), .CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underflow    (underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t, model t=%0d)", tag, got, exp, $time, m_t);
    end
  endtask

  // Expected serial bit at slot position b for frame data l/r.
  function automatic logic exp_sdata(input int b, input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [DW-1:0] v;
`ifdef I2S_LEFT_JUSTIFIED_EN
    if (b < DW) begin
      v = l >> (DW - 1 - b);
      return v[0];
    end
    if (b >= 32 && b < 32 + DW) begin
      v = r >> (DW - 1 - (b - 32));
      return v[0];
    end
`else
    if (b >= 1 && b <= DW) begin
      v = l >> (DW - b);
      return v[0];
    end
    if (b >= 33 && b <= 32 + DW) begin
      v = r >> (DW - (b - 32));
      return v[0];
    end
`endif
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic accept;
    logic load;
    if (!rst_n) begin
      m_running  = 1'b0;
      m_draining = 1'b0;
      m_t        = 0;
      m_full     = 1'b0;
      m_fs       = 1'b0;
      m_uf       = 1'b0;
      return;
    end
    accept = sample_valid && !m_full;
    load   = 1'b0;
    if (!m_running) begin
      if (en) begin
        m_running  = 1'b1;
        m_draining = 1'b0;
        m_t        = 0;
        load       = 1'b1;
      end
    end else begin
      if (m_t + 1 == FRAME) begin
        m_t = 0;
        if (m_draining && !en) begin
          m_running = 1'b0;
        end else begin
          load = 1'b1;
        end
      end else begin
        m_t = m_t + 1;
      end
      if (m_running) begin
        m_draining = !en;
      end
    end
    m_fs = load;
    m_uf = load && !m_full;
    if (load) begin
      m_fl = m_full ? m_hl : '0;
      m_fr = m_full ? m_hr : '0;
    end
    if (accept) begin
      m_full = 1'b1;
      m_hl   = sample_l;
      m_hr   = sample_r;
    end else if (load) begin
      m_full = 1'b0;
    end
  endtask

  // One clock: update the model at the rising edge, compare on the falling edge.
  task automatic tick();
    int b;
    int e_bclk;
    int e_lrck;
    int e_sd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_running) begin
      b      = (m_t / BIT_CLKS) % 64;
      e_bclk = (m_t / CLK_DIV) % 2;
      e_lrck = (b >= 32) ? 1 : 0;
      e_sd   = int'(exp_sdata(b, m_fl, m_fr));
    end else begin
      e_bclk = 0;
      e_lrck = 0;
      e_sd   = 0;
    end
    check_eq("bclk",         32'(bclk),         32'(e_bclk));
    check_eq("lrck",         32'(lrck),         32'(e_lrck));
    check_eq("sdata",        32'(sdata),        32'(e_sd));
    check_eq("frame_start",  32'(frame_start),  32'(m_fs));
    check_eq("underflow",    32'(underflow),    32'(m_uf));
    check_eq("sample_ready", 32'(sample_ready), 32'(!m_full));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  // Run until the model reaches slot position b, bounded by two frames.
  task automatic wait_slot(input int b);
    int guard;
    guard = 0;
    while (!(m_running && m_t == b * BIT_CLKS) && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    check_eq("wait_slot_reached", 32'(guard < 2 * FRAME), 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    run(3);
    rst_n = 1'b1;
    run(2);

    // Pre-load a pair while idle, then enable: entry frame carries it.
    sample_l     = 16'hA5F0;
    sample_r     = 16'h0F0F;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    en           = 1'b1;
    tick();
    // Second frame pattern, then starve the third frame.
    sample_l     = 16'h8001;
    sample_r     = 16'h7FFE;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    run(2 * FRAME + 20);

    // Continuous valid with fresh random data every cycle.
    sample_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      sample_l = DW'($urandom);
      sample_r = DW'($urandom);
      tick();
    end

    // Drop en mid-frame, re-raise during drain: no gap expected.
    wait_slot(20);
    en = 1'b0;
    wait_slot(50);
    en = 1'b1;
    run(FRAME);

    // Drop en and let the frame drain to idle.
    wait_slot(20);
    en = 1'b0;
    run(FRAME + 40);

    // Reset pulse at slot 40 while running with a held sample.
    en = 1'b1;
    wait_slot(40);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(FRAME + 10);

    // Randomized traffic, enable toggles and occasional reset.
    for (int blk = 0; blk < 30; blk++) begin
      int p;
      p = $urandom_range(0, 100);
      for (int i = 0; i < FRAME; i++) begin
        sample_valid = ($urandom_range(0, 99) < p);
        sample_l     = DW'($urandom);
        sample_r     = DW'($urandom);
        if ($urandom_range(0, 699) == 0) begin
          en = ~en;
        end
        rst_n = ($urandom_range(0, 4999) != 0);
        tick();
      end
    end
    rst_n = 1'b1;
    en    = 1'b0;
    sample_valid = 1'b0;
    run(FRAME + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
